backup_memory: RTL and testbench
================================

Name: backup_memory

Overview:
- Behavioural/synthesizable line-oriented backing store on the host-side backup-memory path, clocked by the host clock.
- Serves the wide request/response memory protocol: one command per cache line, moved as REFILL_CYCLES data beats.
- Writes consume beats from a separate data channel. Reads stream beats back with the request tag and no response backpressure.
- Storage array is named ram and can be preloaded by $readmemh, one DATA_BITS word per line.

Parameters:
- DATA_BITS, 128, width of one data beat.
- ADDR_BITS, 26, line-address width (byte address = {addr, 6'b0}).
- TAG_BITS, 5, request/response tag width.
- REFILL_CYCLES, 4, beats per line (power of two).
- LINE_IDX_BITS, 14, implemented line-index bits; depth = 2^LINE_IDX_BITS * REFILL_CYCLES words.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- mem_req_valid  in  1  command valid.
- mem_req_ready  out  1  command accepted when valid&&ready.
- mem_req_rw  in  1  1 = write, 0 = read.
- mem_req_addr  in  ADDR_BITS  line address.
- mem_req_tag  in  TAG_BITS  request tag.
- mem_req_data_valid  in  1  write-data beat valid.
- mem_req_data_ready  out  1  write-data beat accepted when valid&&ready.
- mem_req_data_bits  in  DATA_BITS  write-data beat.
- mem_resp_valid  out  1  read beat valid (no ready; consumer must always accept).
- mem_resp_data  out  DATA_BITS  read beat.
- mem_resp_tag  out  TAG_BITS  tag of the read being returned.

Behaviour:
- States: IDLE, WRITE, READ. Registers:
  - addr_r: low LINE_IDX_BITS of mem_req_addr; upper bits ignored, so addresses wrap modulo depth.
  - tag_r, rw_r.
  - beat counter cnt, log2(REFILL_CYCLES) bits.
- Word index = {addr_r, cnt}.
- Reset (reset==0 at a rising edge):
  - state=IDLE, cnt=0, addr_r=0, tag_r=0.
  - Outputs while in reset and in the following IDLE: mem_req_ready=0 during reset, mem_req_data_ready=0, mem_resp_valid=0, mem_resp_tag=0, mem_resp_data=don't-care.
  - ram contents are never cleared by reset.
- Reset mid-operation aborts the transaction. Beats already written stay written. No further response beats are produced.
- IDLE:
  - mem_req_ready=1 (when not in reset).
  - On a command handshake, latch addr/tag/rw and set cnt=0.
  - Next state is WRITE if rw=1, else READ.
  - Data beats presented in IDLE are not accepted (data_ready=0).
- WRITE:
  - mem_req_ready=0, mem_req_data_ready=1.
  - Each data handshake writes ram[{addr_r,cnt}] <= data_bits and increments cnt.
  - data_valid low stalls with no side effects.
  - On the handshake with cnt==REFILL_CYCLES-1, return to IDLE with cnt wrapped to 0.
  - Writes generate no response.
- READ:
  - mem_req_ready=0, mem_resp_valid=1.
  - mem_resp_data = ram[{addr_r,cnt}] (combinational array read of registered index); mem_resp_tag = tag_r.
  - cnt increments every cycle.
  - After the beat with cnt==REFILL_CYCLES-1, go to IDLE.
- Timing:
  - Command accepted at edge N gives read beats in cycles N+1..N+REFILL_CYCLES, beat k = word {addr,k}.
  - Minimum one IDLE cycle between consecutive commands.
- Read-after-write to the same line returns the newly written data.
- Only one outstanding transaction; no reordering.

Decomposition:
- Shared package backup_memory_pkg:
  - state enum {IDLE, WRITE, READ};
  - default constants DATA_BITS / ADDR_BITS / TAG_BITS / REFILL_CYCLES;
  - CNT_BITS = $clog2(REFILL_CYCLES).
- One natural sub-module: backup_memory_ram, a 1-write/1-async-read array instance named ram (so hierarchical $readmemh to <inst>.ram works).
- FSM and counters stay in the top.

Test Plan:
- Write line addr=0x10, tag=3, beats 0xA0..0xA3 back-to-back -> data_ready high for exactly 4 handshakes, no resp_valid; then read addr=0x10 tag=7 -> resp_valid for 4 consecutive cycles starting the cycle after accept, data A0,A1,A2,A3, tag=7 on all beats.
- Write with data_valid toggling 1,0,0,1,1,0,1 -> exactly 4 words written in order; FSM leaves WRITE only after the 4th beat; mem_req_ready stays 0 throughout.
- Preload ram via $readmemh with word i = i; read addr=2 -> beats 8,9,10,11.
- Address wrap: write line 2^LINE_IDX_BITS+5, read line 5 -> same data returned.
- Reset: drive reset=0 after 2 of 4 write beats, then release -> mem_req_ready=0 while in reset, then 1; data_ready=0, resp_valid=0; the first 2 words hold new data, remaining words unchanged.
- Back-to-back: present a read command continuously while a write is in progress -> command accepted only in IDLE, exactly one cycle after the last write beat.

Source files
------------

// File: rtl/backup_memory_pkg.sv
// Shared definitions for the backup-memory line store: FSM state encoding
// and the default geometry of the wide request/response memory protocol.
package backup_memory_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int DATA_BITS     = 128;  // width of one data beat
    localparam int ADDR_BITS     = 26;   // line address width
    localparam int TAG_BITS      = 5;    // request/response tag width
    localparam int REFILL_CYCLES = 4;    // beats per line, power of two
    localparam int LINE_IDX_BITS = 14;   // implemented line-index bits
    localparam int CNT_BITS      = $clog2(REFILL_CYCLES);

endpackage

// File: rtl/backup_memory_ram.sv
// Word array behind the backup-memory FSM: one synchronous write port and one
// asynchronous read port sharing a single word index.
// Ports:
//   clk   - clock, write happens on the rising edge
//   we    - write enable
//   addr  - word index used for both write and read
//   wdata - word to store
//   rdata - word currently stored at addr (combinational)
// The storage array is called ram so it can be preloaded hierarchically.
module backup_memory_ram
    import backup_memory_pkg::*;
#(
    parameter int DATA_BITS = backup_memory_pkg::DATA_BITS,
    parameter int IDX_BITS  = backup_memory_pkg::LINE_IDX_BITS + backup_memory_pkg::CNT_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] ram [0:(1 << IDX_BITS) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    assign rdata = ram[addr];

endmodule

// File: rtl/backup_memory.sv
// Line-oriented backing store on the host backup-memory path. One command
// moves a whole cache line as REFILL_CYCLES beats; writes take beats from the
// data channel, reads stream beats back with the request tag.
// Ports:
//   clk, reset                 - clock, synchronous active-low reset
//   mem_req_valid/ready        - command channel
//   mem_req_rw/addr/tag        - command payload (rw=1 write, addr = line)
//   mem_req_data_valid/ready   - write-data channel
//   mem_req_data_bits          - write-data beat
//   mem_resp_valid/data/tag    - read beats, no backpressure
//   fsm_state                  - current FSM state, for observation
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and ready here depends only on
// state and reset, never on the incoming valid. The response channel has no
// ready, so every cycle with mem_resp_valid high is a delivered beat.
module backup_memory
    import backup_memory_pkg::*;
#(
    parameter int DATA_BITS     = backup_memory_pkg::DATA_BITS,
    parameter int ADDR_BITS     = backup_memory_pkg::ADDR_BITS,
    parameter int TAG_BITS      = backup_memory_pkg::TAG_BITS,
    parameter int REFILL_CYCLES = backup_memory_pkg::REFILL_CYCLES,
    parameter int LINE_IDX_BITS = backup_memory_pkg::LINE_IDX_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_req_valid,
    output logic                 mem_req_ready,
    input  logic                 mem_req_rw,
    input  logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic [TAG_BITS-1:0]  mem_req_tag,
    input  logic                 mem_req_data_valid,
    output logic                 mem_req_data_ready,
    input  logic [DATA_BITS-1:0] mem_req_data_bits,
    output logic                 mem_resp_valid,
    output logic [DATA_BITS-1:0] mem_resp_data,
    output logic [TAG_BITS-1:0]  mem_resp_tag,
    output state_t               fsm_state
);

    localparam int CNT_BITS = $clog2(REFILL_CYCLES);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(REFILL_CYCLES - 1);

    state_t                   state, state_n;
    logic [LINE_IDX_BITS-1:0] addr_r, addr_n;
    logic [TAG_BITS-1:0]      tag_r, tag_n;
    logic                     rw_r, rw_n;
    logic [CNT_BITS-1:0]      cnt, cnt_n;
    logic                     ram_we;

    // Upper line-address bits are deliberately dropped: lines wrap modulo depth.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, mem_req_addr[ADDR_BITS-1:LINE_IDX_BITS]};

    always_comb begin
        state_n            = state;
        addr_n             = addr_r;
        tag_n              = tag_r;
        rw_n               = rw_r;
        cnt_n              = cnt;
        ram_we             = 1'b0;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_tag       = '0;

        // Every output is qualified by reset so nothing is offered or
        // returned while the block is being held in reset.
        case (state)
            IDLE: begin
                mem_req_ready = reset;
                if (mem_req_valid && reset) begin
                    addr_n  = mem_req_addr[LINE_IDX_BITS-1:0];
                    tag_n   = mem_req_tag;
                    rw_n    = mem_req_rw;
                    cnt_n   = '0;
                    state_n = mem_req_rw ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_req_data_ready = reset;
                if (mem_req_data_valid && reset) begin
                    ram_we = rw_r;
                    cnt_n  = cnt + CNT_BITS'(1);
                    if (cnt == LAST_BEAT) begin
                        state_n = IDLE;
                    end
                end
            end
            READ: begin
                mem_resp_valid = reset;
                mem_resp_tag   = reset ? tag_r : '0;
                cnt_n          = cnt + CNT_BITS'(1);
                if (cnt == LAST_BEAT) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_r <= '0;
            tag_r  <= '0;
            rw_r   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_r <= addr_n;
            tag_r  <= tag_n;
            rw_r   <= rw_n;
        end
    end

    backup_memory_ram #(
        .DATA_BITS (DATA_BITS),
        .IDX_BITS  (LINE_IDX_BITS + CNT_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  ({addr_r, cnt}),
        .wdata (mem_req_data_bits),
        .rdata (mem_resp_data)
    );

    assign fsm_state = state;

endmodule

// File: tb/tb_backup_memory.sv
module tb_backup_memory;
  import backup_memory_pkg::*;

  localparam int DW = 128;
  localparam int AW = 26;
  localparam int TW = 5;
  localparam int R  = 4;
  localparam int LB = 14;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req_valid = 1'b0;
  logic          mem_req_ready;
  logic          mem_req_rw = 1'b0;
  logic [AW-1:0] mem_req_addr = '0;
  logic [TW-1:0] mem_req_tag = '0;
  logic          mem_req_data_valid = 1'b0;
  logic          mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits = '0;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [TW-1:0] mem_resp_tag;
  state_t        fsm_state;

  always #5 clk = ~clk;

  backup_memory dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_rw         (mem_req_rw),
    .mem_req_addr       (mem_req_addr),
    .mem_req_tag        (mem_req_tag),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data),
    .mem_resp_tag       (mem_resp_tag),
    .fsm_state          (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q[$];
  logic [TW-1:0] exp_tag_q[$];
  logic [DW-1:0] beats[4];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Tracks only "beats still owed" per transaction and a word-indexed memory.
  logic [DW-1:0] mem_model[int];
  int            wr_left = 0;
  int            rd_left = 0;
  int            m_line = 0;
  logic [TW-1:0] m_tag = '0;
  bit            started = 0;

  always @(posedge clk) begin
    started = 1;
    if (!reset) begin
      wr_left = 0;
      rd_left = 0;
    end else if (wr_left > 0) begin
      if (mem_req_data_valid) begin
        mem_model[m_line * R + (R - wr_left)] = mem_req_data_bits;
        wr_left--;
      end
    end else if (rd_left > 0) begin
      rd_left--;
    end else if (mem_req_valid) begin
      m_line = int'(mem_req_addr) % (1 << LB);
      m_tag  = mem_req_tag;
      if (mem_req_rw) wr_left = R;
      else            rd_left = R;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  bit     m_idle;
  state_t exp_st;
  int     m_key;

  always @(negedge clk) begin
    if (started) begin
      m_idle = (wr_left == 0) && (rd_left == 0);
      if (wr_left > 0)      exp_st = WRITE;
      else if (rd_left > 0) exp_st = READ;
      else                  exp_st = IDLE;
      check("req_ready", DW'(mem_req_ready), DW'(reset && m_idle));
      check("data_ready", DW'(mem_req_data_ready), DW'(reset && wr_left > 0));
      check("resp_valid", DW'(mem_resp_valid), DW'(reset && rd_left > 0));
      check("state", DW'(fsm_state), DW'(exp_st));
      if (reset && rd_left > 0) begin
        m_key = m_line * R + (R - rd_left);
        if (mem_model.exists(m_key)) check("resp_data", mem_resp_data, mem_model[m_key]);
        check("resp_tag", DW'(mem_resp_tag), DW'(m_tag));
      end else begin
        check("resp_tag_idle", DW'(mem_resp_tag), '0);
      end
    end
  end

  // ---------------- literal expectations for read beats ----------------
  logic [DW-1:0] lit_d;
  logic [TW-1:0] lit_t;

  always @(negedge clk) begin
    if (started && reset && mem_resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", DW'(mem_resp_valid), '0);
      end else begin
        lit_d = exp_q.pop_front();
        lit_t = exp_tag_q.pop_front();
        check("beat_data", mem_resp_data, lit_d);
        check("beat_tag", DW'(mem_resp_tag), DW'(lit_t));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic rw, input int line, input logic [TW-1:0] tag);
    bit done = 0;
    mem_req_valid = 1'b1;
    mem_req_rw    = rw;
    mem_req_addr  = AW'(line);
    mem_req_tag   = tag;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = mem_req_ready;
      step();
    end
    mem_req_valid = 1'b0;
    check("cmd_accept", DW'(done), DW'(1));
  endtask

  // Presents beats[] with a valid pattern (bit i = cycle i, then all ones)
  // until nbeats handshakes have happened.
  task automatic send_data(input logic [15:0] pat, input int plen, input int nbeats);
    int n = 0;
    for (int i = 0; i < 40 && n < nbeats; i++) begin
      mem_req_data_valid = (i < plen) ? pat[i] : 1'b1;
      mem_req_data_bits  = beats[n];
      @(negedge clk);
      if (mem_req_data_valid && mem_req_data_ready) n++;
      step();
    end
    mem_req_data_valid = 1'b0;
    check("write_beats", DW'(n), DW'(nbeats));
  endtask

  task automatic write_line(input int line, input logic [TW-1:0] tag, input logic [15:0] pat, input int plen);
    send_cmd(1'b1, line, tag);
    send_data(pat, plen, R);
    @(negedge clk);
    check("idle_after_write", DW'(fsm_state), DW'(IDLE));
    step();
  endtask

  task automatic read_line(input int line, input logic [TW-1:0] tag);
    for (int k = 0; k < R; k++) begin
      exp_q.push_back(beats[k]);
      exp_tag_q.push_back(tag);
    end
    send_cmd(1'b0, line, tag);
    repeat (R + 1) step();
    check("beats_drained", DW'(exp_q.size()), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    @(negedge clk);
    check("reset_req_ready", DW'(mem_req_ready), '0);
    reset = 1'b1;
    step();

    // Basic line write then read back.
    beats = '{128'hA0, 128'hA1, 128'hA2, 128'hA3};
    write_line(32'h10, 5'd3, 16'hFFFF, 0);
    read_line(32'h10, 5'd7);

    // Data beats offered while idle must be ignored.
    mem_req_data_valid = 1'b1;
    mem_req_data_bits  = 128'hDEAD;
    repeat (2) step();
    mem_req_data_valid = 1'b0;
    read_line(32'h10, 5'd2);

    // Write with a gappy valid pattern 1,0,0,1,1,0,1.
    beats = '{128'hD0, 128'hD1, 128'hD2, 128'hD3};
    write_line(32'h11, 5'd4, 16'b1011001, 7);
    read_line(32'h11, 5'd5);

    // Lines 0..3 hold word i = i; line 2 must read back 8..11.
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < R; k++) beats[k] = DW'(j * R + k);
      write_line(j, 5'd1, 16'hFFFF, 0);
    end
    beats = '{128'd8, 128'd9, 128'd10, 128'd11};
    read_line(2, 5'd6);

    // Address wrap modulo the implemented depth.
    beats = '{128'hE0, 128'hE1, 128'hE2, 128'hE3};
    write_line((1 << LB) + 5, 5'd8, 16'hFFFF, 0);
    read_line(5, 5'd10);

    // Reset in the middle of a write.
    beats = '{128'hB0, 128'hB1, 128'hB2, 128'hB3};
    write_line(32'h20, 5'd11, 16'hFFFF, 0);
    beats = '{128'hC0, 128'hC1, 128'hC2, 128'hC3};
    send_cmd(1'b1, 32'h20, 5'd12);
    send_data(16'hFFFF, 0, 2);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", DW'(mem_req_ready), '0);
    check("rst_data_ready", DW'(mem_req_data_ready), '0);
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rel_req_ready", DW'(mem_req_ready), DW'(1));
    check("rel_data_ready", DW'(mem_req_data_ready), '0);
    check("rel_resp_valid", DW'(mem_resp_valid), '0);
    step();
    beats = '{128'hC0, 128'hC1, 128'hB2, 128'hB3};
    read_line(32'h20, 5'd13);

    // Read command held while a write is in flight.
    beats = '{128'hF0, 128'hF1, 128'hF2, 128'hF3};
    send_cmd(1'b1, 32'h30, 5'd14);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = AW'(32'h10);
    mem_req_tag   = 5'd9;
    for (int k = 0; k < R; k++) begin
      exp_q.push_back(DW'(128'hA0 + k));
      exp_tag_q.push_back(5'd9);
    end
    send_data(16'b101, 3, R);
    @(negedge clk);
    check("b2b_ready", DW'(mem_req_ready), DW'(1));
    step();
    mem_req_valid = 1'b0;
    repeat (R + 1) step();
    check("b2b_drained", DW'(exp_q.size()), '0);

    beats = '{128'hF0, 128'hF1, 128'hF2, 128'hF3};
    read_line(32'h30, 5'd15);

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
